// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller and its datapath muxes.
// MAIN_FSM_LUI_EN adds the LUI state to the state enum.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
`ifdef MAIN_FSM_LUI_EN
    , S_LUI    = 4'd11
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_READ_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_A      = 2'b10;
  localparam logic [1:0] SRCA_IMM    = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS_A = 2'b11;

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: state register, next-state logic and Moore output decode.
// Define MAIN_FSM_LUI_EN to support LUI; otherwise op 0110111 is treated as illegal.
module main_fsm
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  state_t state_r;
  state_t next_state_s;
  logic   pc_update_s;
  logic   branch_s;
  logic   ir_write_s;
  logic   mem_write_s;
  logic   reg_write_s;
  logic   illegal_op_s;

  // State register; reset parks the controller in FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    next_state_s = S_FETCH;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    illegal_op_s = 1'b0;
    adr_src      = 1'b0;
    result_src   = RES_ALU_OUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_update_s  = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALU_RESULT;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECUTER;
          OP_ITYPE:          next_state_s = S_EXECUTEI;
          OP_JAL:            next_state_s = S_JAL;
          OP_BEQ:            next_state_s = S_BEQ;
`ifdef MAIN_FSM_LUI_EN
          OP_LUI:            next_state_s = S_LUI;
`endif
          default: begin
            next_state_s = S_FETCH;
            illegal_op_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        if (op == OP_LOAD) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src      = 1'b1;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = RES_READ_DATA;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src      = 1'b1;
        mem_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a    = SRCA_A;
        alu_op       = ALU_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        alu_src_a    = SRCA_OLD_PC;
        alu_src_b    = SRCB_FOUR;
        pc_update_s  = 1'b1;
        next_state_s = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a    = SRCA_A;
        alu_op       = ALU_SUB;
        branch_s     = 1'b1;
        next_state_s = S_FETCH;
      end
`ifdef MAIN_FSM_LUI_EN
      S_LUI: begin
        alu_src_a    = SRCA_IMM;
        alu_op       = ALU_PASS_A;
        next_state_s = S_ALUWB;
      end
`endif
      default: next_state_s = S_FETCH;
    endcase
  end

  // Write enables are killed combinationally so an abandoned instruction commits nothing
  assign pc_write   = ~reset & (pc_update_s | (branch_s & zero));
  assign ir_write   = ~reset & ir_write_s;
  assign mem_write  = ~reset & mem_write_s;
  assign reg_write  = ~reset & reg_write_s;
  assign illegal_op = ~reset & illegal_op_s;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: instruction-level reference model plus directed literal checks.
module tb_main_fsm;

  typedef enum int {C_LW, C_SW, C_R, C_I, C_JAL, C_BEQ, C_LUI, C_ILL} cls_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } outs_t;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  int         total;
  int         bad;
  cls_t       cls;
  int         k;
  logic [6:0] nxt_op;
  bit         model_on;
  bit         rq;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cls_t classify(input logic [6:0] o);
    case (o)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1101111: return C_JAL;
      7'b1100011: return C_BEQ;
`ifdef MAIN_FSM_LUI_EN
      7'b0110111: return C_LUI;
`endif
      default:    return C_ILL;
    endcase
  endfunction

  function automatic int ilen(input cls_t c);
    case (c)
      C_LW:    return 5;
      C_BEQ:   return 3;
      C_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  // Expected outputs from instruction class and cycle index within the instruction
  function automatic outs_t model_out();
    outs_t o;
    o = '0;
    if (k == 0) begin
      o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
    end else if (k == 1) begin
      o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.illegal_op = (cls == C_ILL);
    end else begin
      case (cls)
        C_LW, C_SW: begin
          if (k == 2) begin
            o.alu_src_a = 2'b10; o.alu_src_b = 2'b01;
          end else if (k == 3) begin
            o.adr_src = 1'b1; o.mem_write = (cls == C_SW);
          end else begin
            o.reg_write = 1'b1; o.result_src = 2'b01;
          end
        end
        C_BEQ: begin
          o.alu_src_a = 2'b10; o.alu_op = 2'b01; o.pc_write = zero;
        end
        default: begin
          if (k == 3) o.reg_write = 1'b1;
          else if (cls == C_R) begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
          else if (cls == C_I) begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10; end
          else if (cls == C_JAL) begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1; end
          else begin o.alu_src_a = 2'b11; o.alu_op = 2'b11; end
        end
      endcase
    end
    if (reset) begin
      o.pc_write = 1'b0; o.ir_write = 1'b0; o.mem_write = 1'b0;
      o.reg_write = 1'b0; o.illegal_op = 1'b0;
    end
    return o;
  endfunction

  function automatic logic [6:0] rand_op();
    logic [6:0] pool [9];
    int         idx;
    pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
             7'b1100011, 7'b0110111, 7'b1111111, 7'b0000000};
    idx = int'($urandom_range(0, 9));
    if (idx == 9) return 7'($urandom);
    return pool[idx];
  endfunction

  task automatic begin_instr(input logic [6:0] o);
    op  = o;
    cls = classify(o);
  endtask

  // One clock: advance the model to the state the DUT enters at this edge
  task automatic step(input bit rst_req);
    @(posedge clk);
    #1;
    if (rst_req) begin
      reset = 1'b1;
      k = 0;
    end else if (reset) begin
      reset = 1'b0;
      k = 0;
      begin_instr(nxt_op);
    end else begin
      k = k + 1;
      if (k >= ilen(cls)) begin
        k = 0;
        begin_instr(nxt_op);
      end
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Every-cycle comparison against the reference model
  always @(negedge clk) begin
    outs_t e;
    outs_t a;
    if (model_on) begin
      e = model_out();
      a = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, illegal_op};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL model k=%0d op=%b reset=%b actual=%b required=%b", k, op, reset, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; model_on = 1'b0;
    reset = 1'b1; zero = 1'b0; k = 0; nxt_op = 7'b0;
    begin_instr(7'b0000000);
    #2;
    chk1("rst_ir_write", ir_write, 1'b0);
    chk1("rst_pc_write", pc_write, 1'b0);
    chk2("rst_src_b", alu_src_b, 2'b10);
    model_on = 1'b1;

    // load word: five cycles, register write only in the last
    nxt_op = 7'b0000011;
    for (int i = 0; i < 5; i++) begin
      step(1'b0); #1;
      chk1("lw_reg_write", reg_write, (i == 4));
      if (i == 4) chk2("lw_result_src", result_src, 2'b01);
    end

    // branch taken then not taken
    for (int t = 0; t < 2; t++) begin
      nxt_op = 7'b1100011;
      for (int i = 0; i < 3; i++) begin
        step(1'b0);
        zero = (t == 0);
        #1;
        if (t == 0) chk1("beq_taken_pc_write", pc_write, (i != 1));
        else        chk1("beq_nt_pc_write", pc_write, (i == 0));
      end
    end

    // jal
    nxt_op = 7'b1101111;
    for (int i = 0; i < 4; i++) begin
      step(1'b0); zero = 1'b0; #1;
      if (i == 0) chk1("beq_back_fetch", ir_write, 1'b1);
      if (i == 2) begin
        chk1("jal_pc_write", pc_write, 1'b1);
        chk2("jal_src_a", alu_src_a, 2'b01);
        chk2("jal_src_b", alu_src_b, 2'b10);
      end
      if (i == 3) begin
        chk1("jal_wb_reg_write", reg_write, 1'b1);
        chk2("jal_wb_result_src", result_src, 2'b00);
      end
    end

    // lui
    nxt_op = 7'b0110111;
`ifdef MAIN_FSM_LUI_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b0); #1;
      if (i == 2) begin
        chk2("lui_src_a", alu_src_a, 2'b11);
        chk2("lui_alu_op", alu_op, 2'b11);
      end
      if (i == 3) chk1("lui_reg_write", reg_write, 1'b1);
    end
`else
    for (int i = 0; i < 2; i++) begin
      step(1'b0); #1;
      chk1("lui_illegal", illegal_op, (i == 1));
    end
`endif

    // unsupported opcode
    nxt_op = 7'b1111111;
    for (int i = 0; i < 2; i++) begin
      step(1'b0); #1;
      chk1("ill_pulse", illegal_op, (i == 1));
      chk1("ill_writes", |{pc_write, ir_write, mem_write, reg_write}, (i == 0));
    end

    // store, then reset in the middle of MEMWRITE
    nxt_op = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      step(1'b0); #1;
      if (i == 0) chk1("ill_then_fetch", illegal_op, 1'b0);
      if (i == 3) chk1("sw_mem_write", mem_write, 1'b1);
    end
    reset = 1'b1; k = 0;
    #1;
    chk1("rst_kills_mem_write", mem_write, 1'b0);
    chk1("rst_kills_ir_write", ir_write, 1'b0);
    nxt_op = 7'b0110011;
    step(1'b0); #1;
    chk1("rel_ir_write", ir_write, 1'b1);
    chk1("rel_pc_write", pc_write, 1'b1);
    chk2("rel_src_a", alu_src_a, 2'b00);
    chk2("rel_src_b", alu_src_b, 2'b10);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      nxt_op = rand_op();
      if (reset) rq = ($urandom_range(0, 2) == 0);
      else       rq = ($urandom_range(0, 39) == 0);
      step(rq);
      zero = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
